// File: rtl/control_unit_pkg.sv
// Shared constants for the control_unit sequencer: FSM state codes, opcodes
// and instruction field positions.
package control_unit_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH     = 3'd0;
    localparam state_t ST_DECODE    = 3'd1;
    localparam state_t ST_EXECUTE   = 3'd2;
    localparam state_t ST_WRITEBACK = 3'd3;
    localparam state_t ST_HALT      = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/control_unit_regfile.sv
// 8x8 register file: two combinational read ports, a debug read port and one
// synchronous write port, cleared asynchronously.
module control_unit_regfile #(
    parameter int NREGS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr_a,
    input  logic [2:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    input  logic [2:0] dbg_sel,
    output logic [7:0] dbg_data
);

    logic [7:0] regs_q [NREGS];
    logic [7:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit core, driving an external ALU.
// state     | meaning
// FETCH     | imem_req held with imem_addr=pc until ack; IR captured on ack
// DECODE    | latch ALU operands, or resolve LDI/jump/branch/NOP/HALT
// EXECUTE   | ALU operands stable; capture result and flags at the edge
// WRITEBACK | write ALU result or LDI immediate, advance pc
// HALT      | absorbing until reset
module control_unit
    import control_unit_pkg::*;
#(
    parameter int         NREGS    = 8,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic [2:0]  dbg_sel,
    output logic [7:0]  dbg_data,
    output logic [7:0]  pc,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        halted
);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        req_q, req_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  result_q, result_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic [7:0]  rdata_a, rdata_b;
    logic        rf_we;
    logic [7:0]  rf_wdata;

    assign op  = ir_q[OP_MSB:OP_LSB];
    assign rd  = ir_q[RD_MSB:RD_LSB];
    assign rs  = ir_q[RS_MSB:RS_LSB];
    assign rt  = ir_q[RT_MSB:RT_LSB];
    assign imm = ir_q[IMM_MSB:IMM_LSB];

    control_unit_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (rf_wdata),
        .raddr_a  (rs),
        .raddr_b  (rt),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        rf_we    = 1'b0;
        rf_wdata = op[3] ? imm : result_q;

        case (state_q)
            ST_FETCH: begin
                // an ack is only honoured while the request is actually out
                if (req_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_alu_op(op)) begin
                    alu_a_d  = rdata_a;
                    alu_b_d  = rdata_b;
                    alu_op_d = op[2:0];
                    state_d  = ST_EXECUTE;
                end else begin
                    state_d = ST_FETCH;
                    case (op)
                        OP_LDI:  state_d = ST_WRITEBACK;
                        OP_JMP:  pc_d = imm;
                        OP_JZ:   pc_d = zero_q  ? imm : pc_q + 8'd1;
                        OP_JC:   pc_d = carry_q ? imm : pc_q + 8'd1;
                        OP_HALT: state_d = ST_HALT;
                        default: pc_d = pc_q + 8'd1;
                    endcase
                end
            end
            ST_EXECUTE: begin
                result_d = alu_out;
                zero_d   = alu_zero;
                if (op == OP_ADD) begin
                    carry_d = alu_carry;
                end
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_d    = pc_q + 8'd1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // registered so the request stays low for the first cycle out of reset
        req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            req_q    <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: bench-side ALU and memory, instruction-level model.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_opcode;
    logic        alu_zero, alu_carry;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [7:0]  pc;
    logic        zero_flag, carry_flag, halted;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU semantics: {carry, result}
    function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a, 1'b0};
            default: return {1'b0, a >> 1};
        endcase
    endfunction

    logic [8:0] alu_res;
    always_comb begin
        alu_res   = alu_ref(alu_opcode, alu_a, alu_b);
        alu_out   = alu_res[7:0];
        alu_carry = alu_res[8];
        alu_zero  = (alu_res[7:0] == 8'h00);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // instruction memory and architectural model
    logic [15:0] mem [256];
    logic [7:0]  m_r [8];
    logic [7:0]  m_pc;
    logic        m_zf, m_cf, m_halted;
    int          exp_gap;
    bit          pend_alu;
    logic [7:0]  exp_a, exp_b;
    logic [2:0]  exp_opc;
    int          last_rd;

    function automatic logic [15:0] e_alu(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {1'b0, op, rd, rs, rt, 3'b000};
    endfunction
    function automatic logic [15:0] e_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'h8, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] e_br(input logic [3:0] op, input logic [7:0] t);
        return {op, 4'h0, t};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_pc = 8'h00; m_zf = 1'b0; m_cf = 1'b0; m_halted = 1'b0;
        exp_gap = -1; pend_alu = 1'b0; last_rd = 0;
    endtask

    // returns the number of cycles the instruction occupies with a zero-wait fetch
    task automatic model_step(input logic [15:0] instr, output int lat);
        logic [3:0] op;
        logic [8:0] r;
        op = instr[15:12];
        lat = 2;
        if (op < 4'h8) begin
            r = alu_ref(op[2:0], m_r[instr[8:6]], m_r[instr[5:3]]);
            m_r[instr[11:9]] = r[7:0];
            m_zf = (r[7:0] == 8'h00);
            if (op == 4'h0) m_cf = r[8];
            m_pc = m_pc + 8'd1;
            lat = 4;
        end else if (op == 4'h8) begin
            m_r[instr[11:9]] = instr[7:0];
            m_pc = m_pc + 8'd1;
            lat = 3;
        end else if (op == 4'h9) m_pc = instr[7:0];
        else if (op == 4'hA) m_pc = m_zf ? instr[7:0] : m_pc + 8'd1;
        else if (op == 4'hB) m_pc = m_cf ? instr[7:0] : m_pc + 8'd1;
        else if (op == 4'hF) m_halted = 1'b1;
        else m_pc = m_pc + 8'd1;
    endtask

    task automatic check_reg(input int idx);
        dbg_sel = 3'(idx);
        #1;
        chk($sformatf("dbg_r%0d", idx), {8'h00, dbg_data}, {8'h00, m_r[idx]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rst_req", {15'h0, imem_req}, 16'h0);
        chk("rst_pc", {8'h0, pc}, 16'h0);
        chk("rst_halted", {15'h0, halted}, 16'h0);
        chk("rst_flags", {14'h0, zero_flag, carry_flag}, 16'h0);
        chk("rst_alu", {alu_a, alu_b[4:0], alu_opcode}, 16'h0);
        model_reset();
        for (int i = 0; i < 8; i++) check_reg(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input bit spurious, output int waited, output bit ok);
        waited = 0;
        while (!imem_req && waited < 30) begin
            if (spurious && $urandom_range(0, 2) == 0) begin
                imem_ack  = 1'b1;
                imem_data = 16'($urandom);
            end else begin
                imem_ack = 1'b0;
            end
            @(posedge clk); #1;
            waited++;
            if (pend_alu && waited == 1) begin
                chk("alu_a", {8'h0, alu_a}, {8'h0, exp_a});
                chk("alu_b", {8'h0, alu_b}, {8'h0, exp_b});
                chk("alu_opcode", {13'h0, alu_opcode}, {13'h0, exp_opc});
                pend_alu = 1'b0;
            end
        end
        imem_ack = 1'b0;
        ok = imem_req;
        if (!ok) chk("req_timeout", {15'h0, imem_req}, 16'h1);
    endtask

    task automatic run_prog(input int n, input int max_delay, input bit spurious);
        int waited, d, lat;
        bit ok;
        logic [7:0]  addr0;
        logic [15:0] instr;
        for (int i = 0; i < n; i++) begin
            if (m_halted) begin
                repeat (3) @(posedge clk);
                #1;
                chk("halted", {15'h0, halted}, 16'h1);
                repeat (20) begin
                    @(posedge clk); #1;
                    if (imem_req !== 1'b0) break;
                end
                chk("halt_req", {15'h0, imem_req}, 16'h0);
                chk("halt_pc", {8'h0, imem_addr}, {8'h0, m_pc});
                return;
            end
            wait_req(spurious, waited, ok);
            if (!ok) return;
            if (exp_gap >= 0) chk("latency", 16'(waited), 16'(exp_gap));
            chk("fetch_addr", {8'h0, imem_addr}, {8'h0, m_pc});
            chk("flags", {14'h0, zero_flag, carry_flag}, {14'h0, m_zf, m_cf});
            chk("not_halted", {15'h0, halted}, 16'h0);
            check_reg(last_rd);
            check_reg(int'($urandom_range(0, 7)));
            addr0 = imem_addr;
            d = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
            imem_ack = 1'b0;
            for (int k = 0; k < d; k++) begin
                imem_data = 16'($urandom);
                @(posedge clk); #1;
                chk("req_hold", {15'h0, imem_req}, 16'h1);
                chk("addr_hold", {8'h0, imem_addr}, {8'h0, addr0});
            end
            instr = mem[addr0];
            imem_data = instr;
            imem_ack = 1'b1;
            @(posedge clk); #1;
            imem_ack = 1'b0;
            imem_data = 16'($urandom);
            if (instr[15] == 1'b0) begin
                pend_alu = 1'b1;
                exp_a = m_r[instr[8:6]];
                exp_b = m_r[instr[5:3]];
                exp_opc = instr[14:12];
            end
            if (instr[15:12] <= 4'h8) last_rd = int'(instr[11:9]);
            model_step(instr, lat);
            exp_gap = lat - 1;
        end
    endtask

    initial begin
        int waited;
        bit ok;
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; dbg_sel = '0;
        model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;

        // directed: arithmetic, carry rules, branches
        mem[8'h00] = e_ldi(3'd1, 8'h05);
        mem[8'h01] = e_ldi(3'd2, 8'h03);
        mem[8'h02] = e_alu(3'd0, 3'd3, 3'd1, 3'd2);
        mem[8'h03] = e_ldi(3'd1, 8'hFF);
        mem[8'h04] = e_ldi(3'd2, 8'h01);
        mem[8'h05] = e_alu(3'd0, 3'd3, 3'd1, 3'd2);
        mem[8'h06] = e_alu(3'd1, 3'd4, 3'd1, 3'd2);
        mem[8'h07] = e_br(4'hA, 8'h20);
        mem[8'h08] = e_br(4'hB, 8'h10);
        mem[8'h10] = e_br(4'hA, 8'h20);
        mem[8'h11] = e_alu(3'd0, 3'd6, 3'd1, 3'd2);
        mem[8'h12] = e_br(4'hA, 8'h20);
        mem[8'h20] = e_br(4'h9, 8'h30);
        mem[8'h30] = e_ldi(3'd5, 8'h33);
        mem[8'h31] = e_alu(3'd0, 3'd5, 3'd1, 3'd2);
        do_reset();
        run_prog(15, 0, 1'b0);

        // reset while the ADD into r5 is in EXECUTE
        @(posedge clk); #1;
        chk("exec_alu_a", {8'h0, alu_a}, 16'h00FF);
        chk("exec_alu_b", {8'h0, alu_b}, 16'h0001);
        pend_alu = 1'b0;
        dbg_sel = 3'd5; #1;
        chk("r5_before_rst", {8'h0, dbg_data}, 16'h0033);
        do_reset();

        // reset while a fetch is pending with ack about to arrive
        wait_req(1'b0, waited, ok);
        chk("first_fetch_addr", {8'h0, imem_addr}, 16'h0000);
        @(posedge clk); #1;
        imem_ack = 1'b1;
        imem_data = 16'hF000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drops_req", {15'h0, imem_req}, 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("ack_discarded", {15'h0, imem_req}, 16'h1);

        // pc wrap then HALT at 0x00
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        mem[8'h00] = e_br(4'h9, 8'hFF);
        run_prog(1, 3, 1'b0);
        mem[8'h00] = 16'hF000;
        run_prog(5, 3, 1'b0);

        // random programs with wait states and stray acks
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 16'($urandom);
                if (mem[i][15:12] == 4'hF && $urandom_range(0, 3) != 0) mem[i][15:12] = 4'hC;
            end
            do_reset();
            run_prog(80, 3, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
